// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative one-bit-per-cycle sll/srl.
// Optional signed overflow flag on add/sub when ALU_OVERFLOW_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         alu_control,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero
`ifdef ALU_OVERFLOW_EN
    , output logic             overflow
`endif
);

    // state | meaning
    // IDLE  | waiting for start; single-cycle ops complete here
    // SHIFT | iterating sll/srl one bit per cycle, inputs ignored
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

    state_t             w_state_nxt;
    logic               w_load_result;
    logic               w_start_shift;
    logic [WIDTH-1:0]   w_result_nxt;
    logic [WIDTH-1:0]   w_alu_result;
    logic [WIDTH-1:0]   w_shift_step;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_lt;
    logic               w_is_shift;

    assign w_sum        = operand_a + operand_b;
    assign w_diff       = operand_a - operand_b;
    assign w_lt         = $signed(operand_a) < $signed(operand_b);
    assign w_is_shift   = (alu_control == OP_SLL) || (alu_control == OP_SRL);
    assign w_shift_step = r_left ? (r_work << 1) : (r_work >> 1);

    // Shift codes only reach this path with shamt == 0, so they pass operand_b through.
    always_comb begin
        w_alu_result = '0;
        case (alu_control)
            OP_ADD:         w_alu_result = w_sum;
            OP_SUB:         w_alu_result = w_diff;
            OP_AND:         w_alu_result = operand_a & operand_b;
            OP_OR:          w_alu_result = operand_a | operand_b;
            OP_SLT:         w_alu_result = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLL, OP_SRL: w_alu_result = operand_b;
            default:        w_alu_result = '0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_result = 1'b0;
        w_start_shift = 1'b0;
        w_result_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_is_shift && (shamt != '0)) begin
                        w_start_shift = 1'b1;
                        w_state_nxt   = SHIFT;
                    end else begin
                        w_load_result = 1'b1;
                        w_result_nxt  = w_alu_result;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_ONE) begin
                    w_load_result = 1'b1;
                    w_result_nxt  = w_shift_step;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work   <= '0;
            r_cnt    <= '0;
            r_left   <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_load_result;
            if (w_load_result) begin
                r_result <= w_result_nxt;
            end
            if (w_start_shift) begin
                r_work <= operand_b;
                r_cnt  <= shamt;
                r_left <= (alu_control == OP_SLL);
            end else if (r_state == SHIFT) begin
                r_work <= w_shift_step;
                r_cnt  <= r_cnt - CNT_ONE;
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Only a single-cycle add/sub can set the flag; a finishing shift clears it.
    always_comb begin
        w_ovf_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (alu_control == OP_ADD) begin
                w_ovf_nxt = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end else if (alu_control == OP_SUB) begin
                w_ovf_nxt = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_load_result) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign overflow = r_ovf;
`endif

    assign busy   = (r_state == SHIFT);
    assign done   = r_done;
    assign result = r_result;
    assign zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected results, a monitor checks each done pulse.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  alu_control;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .shamt       (shamt),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero)
`ifdef ALU_OVERFLOW_EN
        , .overflow  (overflow)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no pending op", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, (e.res == 32'd0)});
                chk({e.name, "_cycle"}, cyc, e.cyc);
`ifdef ALU_OVERFLOW_EN
                chk({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Drive one op on the negedge before E0; expected done after E0 (1-cycle) or E0+k (shift).
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sa, input logic [31:0] exp_res,
                         input logic exp_ovf, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        alu_control = op;
        operand_a = a;
        operand_b = b;
        shamt = sa;
        if (push) begin
            e.res  = exp_res;
            e.ovf  = exp_ovf;
            e.name = name;
            e.cyc  = ((op == 3'd6 || op == 3'd7) && sa != 5'd0) ? cyc + 1 + int'(sa) : cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d ops still pending, expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        alu_control = 3'd0;
        operand_a = '0;
        operand_b = '0;
        shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a long shift aborts it silently.
        issue("rst_shift", 3'd6, 32'h0, 32'h0000_0001, 5'd20, 32'h0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'h0);
        chk("abort_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);

        issue("add",     3'd0, 32'h0000_0005, 32'h0000_000A, 5'd0, 32'h0000_000F, 1'b0, 1'b1);
        issue("sub_eq",  3'd1, 32'h0000_0007, 32'h0000_0007, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        issue("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0, 1'b1);
        issue("slt_pos", 3'd4, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        issue("and",     3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 1'b1);
        issue("or",      3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b1);
        drain("alu");

        issue("sll31", 3'd6, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("sll31_busy_cycles", n, 32'd31);
        drain("sll31");

        // A start pulse while busy must neither restart nor queue another op.
        issue("srl4", 3'd7, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        alu_control = 3'd0;
        operand_a = 32'h1;
        operand_b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        drain("srl4");

        issue("sll0", 3'd6, 32'h0, 32'h1234_5678, 5'd0, 32'h1234_5678, 1'b0, 1'b1);
        issue("rsvd", 3'd5, 32'h1234_5678, 32'h1, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        issue("b2b",  3'd0, 32'h0000_0100, 32'h0000_0023, 5'd0, 32'h0000_0123, 1'b0, 1'b1);
        drain("b2b");

        issue("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b1, 1'b1);
        issue("sub_ovf", 3'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        issue("add_1_1", 3'd0, 32'h0000_0001, 32'h0000_0001, 5'd0, 32'h0000_0002, 1'b0, 1'b1);
        drain("ovf");

        // Result and zero are held while idle.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_result", result, 32'h0000_0002);
        chk("hold_done", {31'd0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 3-bit alu_control code produced by the ALU control decoder and performs the operation on two operands.
- Logic and arithmetic ops complete in one cycle. Shifts (sll/srl) run iteratively, one bit per cycle, with a start/busy/done handshake toward the multi-cycle datapath controller.
- Result and zero flag are registered and held until the next operation completes.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only in IDLE
alu_control  input  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 6 sll, 7 srl; 5 reserved
operand_a  input  WIDTH  rs operand
operand_b  input  WIDTH  rt operand; this is the shifted operand for sll/srl
shamt  input  SHAMT_W  shift amount (instr[10:6])
busy  output  1  high while in SHIFT state
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  registered result, held between operations
zero  output  1  combinational (result == 0)

Behaviour:
- Reset, asynchronous, any state: state=IDLE, result=0, done=0, busy=0, so zero=1. Reset mid-shift aborts the operation with no done pulse.
- States: IDLE, SHIFT.
- IDLE with start=0: done=0, result held.
- IDLE with start=1 and a non-shift code, or a shift code with shamt=0, at edge E0:
  - result is loaded with the computed value; done=1 for the cycle after E0; state stays IDLE.
  - Latency is 1 cycle.
- IDLE with start=1, code 6/7, shamt=k>0, at edge E0:
  - Working register loads operand_b; counter loads k; state goes to SHIFT; busy=1.
  - In SHIFT, each edge shifts the working register by 1 (sll: left, zero-fill; srl: logical right, zero-fill) and decrements the counter.
  - On the edge where the counter goes 1->0: result loads the final value, done=1, busy=0, state goes to IDLE.
  - Latency is k cycles; done is visible after edge E0+k.
- Operation code and shift direction are captured at E0. Input changes during SHIFT have no effect.
- start while busy=1 is ignored, not queued.
- start is accepted in the cycle done=1 (back-to-back operations), giving a new done pulse one cycle later for 1-cycle ops.
- Arithmetic rules:
  - add/sub are modulo 2^WIDTH; carry is discarded.
  - slt is a signed compare; result = {WIDTH-1 zeros, (a < b)}.
  - and/or are bitwise.
  - Reserved code 5: result=0, 1-cycle latency, done pulses.
- zero tracks result at all times, including the held value.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: extra output port overflow (1 bit), registered with result. It is set on two's-complement signed overflow of add (a, b same sign, result sign differs) or sub (a, b differ in sign, result sign differs from a). It is 0 for all other codes, 0 on reset, and held between operations.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset asserted mid-SHIFT (sll, shamt=20, reset at cycle 5) -> busy=0, done=0, result=0, zero=1 immediately; no later done pulse.
2. add a=0x00000005, b=0x0000000A -> done one cycle after start, result=0x0000000F, zero=0. Then sub a=7, b=7 -> result=0, zero=1.
3. slt a=0xFFFFFFFF (-1), b=0x00000001 -> result=1. Swap operands -> result=0. and 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0. or of the same operands -> 0xFFF0FFF0.
4. sll b=0x00000001, shamt=31 -> busy high 31 cycles, done exactly at edge E0+31, result=0x80000000. srl b=0x80000000, shamt=4 -> result=0x08000000 after 4 cycles. start pulsed during busy -> ignored.
5. sll shamt=0, b=0x12345678 -> 1-cycle done, result=0x12345678. Code 5 -> result=0, zero=1, 1-cycle done. Back-to-back add issued on the done cycle -> second done the next cycle.
6. With ALU_OVERFLOW_EN: add 0x7FFFFFFF+1 -> result=0x80000000, overflow=1. sub 0x80000000-1 -> overflow=1. add 1+1 -> overflow=0. Build without the macro -> compiles with no overflow port.
